// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if -- instruction-memory read bus between the fetch unit and
// the instruction memory.
//
//   imem_req    fetch -> mem   a read is pending
//   imem_addr   fetch -> mem   byte address of the pending read (word aligned)
//   imem_ready  mem -> fetch   imem_rdata is valid this cycle
//   imem_rdata  mem -> fetch   instruction word returned by memory
//
// master: the fetch unit.  slave: the memory (or a testbench model of it).
// ---------------------------------------------------------------------------
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- two-state instruction fetch unit.
//
// FETCH requests the word at pc from instruction memory and registers it on
// imem_ready. HOLD presents that word to the decoder until it is retired
// (inst_ready), at which point pc advances to the sequential, jump or
// taken-branch target and the retired-instruction counter increments.
//
// Ports
//   clk         clock, all state on the rising edge
//   rstn        synchronous active-low reset
//   imem        instruction-memory bus (inst_fetch_if.master)
//   inst        held instruction word for the decoder
//   inst_valid  inst and pc are valid (HOLD state)
//   inst_ready  decoder retires inst this cycle
//   pc          address of the held / pending instruction
//   jump        decoded jump flag for the held instruction
//   branch      decoded beq flag for the held instruction
//   zero        ALU zero flag for the held instruction
//   retired     count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rstn,
    inst_fetch_if.master        imem,
    output logic [31:0]         inst,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         pc,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    output logic [31:0]         retired
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    // The PC only ever holds word addresses; forcing the low bits of the
    // reset value keeps imem_addr aligned even for an odd RESET_PC.
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    logic [0:0]  state;
    logic [31:0] pc4;
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] next_pc;
    logic signed [31:0] branch_off;

    // Sign-extended, word-scaled 16-bit branch displacement.
    function automatic logic signed [31:0] branch_disp(input logic [15:0] imm);
        branch_disp = signed'({{14{imm[15]}}, imm, 2'b00});
    endfunction

    always_comb begin
        pc4        = pc + 32'd4;
        jump_tgt   = {pc4[31:28], inst[25:0], 2'b00};
        branch_off = branch_disp(inst[15:0]);
        branch_tgt = pc4 + unsigned'(branch_off);
        if (jump) begin
            next_pc = jump_tgt;
        end else if (branch && zero) begin
            next_pc = branch_tgt;
        end else begin
            next_pc = pc4;
        end
    end

    // Outputs are gated by rstn so nothing is requested or presented while
    // reset is held, whatever state the FSM happens to be in.
    always_comb begin
        imem.imem_req  = rstn && (state == FETCH);
        imem.imem_addr = {pc[31:2], 2'b00};
        inst_valid     = rstn && (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= FETCH;
            pc      <= RESET_PC_W;
            inst    <= 32'd0;
            retired <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ready) begin
                        inst  <= imem.imem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc      <= next_pc;
                        retired <= retired + 32'd1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
